// File: rtl/servo_motion_ctrl.sv
// servo_motion_ctrl: touch debounce, open/close target FSM and pulse-width ramp.
// Ramp updates land only on PWM frame boundaries.
//
// Ports:
//   int_osc      in   sole clock
//   reset        in   synchronous, active-high
//   touch_in     in   raw async touch level (1 = touched)
//   frame_start  in   one-cycle pulse at PWM period wrap
//   pulse_width  out  commanded high time in cycles
//   touch_db     out  debounced touch level
//   moving       out  pulse_width differs from target (registered)
//   is_open      out  current target (1 = MAX_PW, 0 = MIN_PW)
module servo_motion_ctrl #(
    parameter logic [31:0] MIN_PW          = 32'd24000,
    parameter logic [31:0] MAX_PW          = 32'd48000,
    parameter logic [31:0] STEP            = 32'd1200,
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd240000
) (
    input  logic        int_osc,
    input  logic        reset,
    input  logic        touch_in,
    input  logic        frame_start,
    output logic [31:0] pulse_width,
    output logic        touch_db,
    output logic        moving,
    output logic        is_open
);

    typedef enum logic [1:0] {
        CLOSED  = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } state_t;

    localparam logic [31:0] DB_LAST = DEBOUNCE_CYCLES - 32'd1;

    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic [31:0] db_cnt_q, db_cnt_d;
    logic        touch_db_q, touch_db_d;
    logic        touch_rise_q, touch_rise_d;
    state_t      state_q, state_d;
    logic [31:0] pw_q, pw_d;
    logic        moving_q, moving_d;
    logic        open_q, open_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] diff;

    always_comb begin
        s1_d       = touch_in;
        s2_d       = s1_q;
        db_cnt_d   = db_cnt_q;
        touch_db_d = touch_db_q;
        if (s2_q == touch_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            touch_db_d = s2_q;
            db_cnt_d   = '0;
        end else begin
            db_cnt_d = db_cnt_q + 32'd1;
        end
        // Registered so the pulse coincides with the first cycle touch_db is high.
        touch_rise_d = touch_db_d & ~touch_db_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLOSED: begin
                if (touch_rise_q) state_d = OPENING;
            end
            OPENING: begin
                if (touch_rise_q)        state_d = CLOSING;
                else if (pw_q == MAX_PW) state_d = OPEN;
            end
            OPEN: begin
                if (touch_rise_q) state_d = CLOSING;
            end
            CLOSING: begin
                if (touch_rise_q)        state_d = OPENING;
                else if (pw_q == MIN_PW) state_d = CLOSED;
            end
            default: state_d = CLOSED;
        endcase
    end

    assign open_q = (state_q == OPENING) || (state_q == OPEN);
    assign open_d = (state_d == OPENING) || (state_d == OPEN);
    assign tgt_q  = open_q ? MAX_PW : MIN_PW;
    // Ramp uses the post-touch target so a coincident touch steers this frame.
    assign tgt_d  = open_d ? MAX_PW : MIN_PW;

    always_comb begin
        pw_d = pw_q;
        diff = '0;
        if (frame_start) begin
            if (tgt_d >= pw_q) begin
                diff = tgt_d - pw_q;
                pw_d = (diff <= STEP) ? tgt_d : pw_q + STEP;
            end else begin
                diff = pw_q - tgt_d;
                pw_d = (diff <= STEP) ? tgt_d : pw_q - STEP;
            end
        end
        moving_d = (pw_q != tgt_q);
    end

    always_ff @(posedge int_osc) begin
        if (reset) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            db_cnt_q     <= '0;
            touch_db_q   <= 1'b0;
            touch_rise_q <= 1'b0;
            state_q      <= CLOSED;
            pw_q         <= MIN_PW;
            moving_q     <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            db_cnt_q     <= db_cnt_d;
            touch_db_q   <= touch_db_d;
            touch_rise_q <= touch_rise_d;
            state_q      <= state_d;
            pw_q         <= pw_d;
            moving_q     <= moving_d;
        end
    end

    assign pulse_width = pw_q;
    assign touch_db    = touch_db_q;
    assign moving      = moving_q;
    assign is_open     = open_q;

endmodule

// File: tb/tb_servo_motion_ctrl.sv
// tb_servo_motion_ctrl: directed scenarios for servo_motion_ctrl.
// Small parameters: debounce 4, pulse width 100..200, step 30.
module tb_servo_motion_ctrl;

    logic        int_osc = 1'b0;
    logic        reset = 1'b0;
    logic        touch_in = 1'b0;
    logic        frame_start = 1'b0;
    logic [31:0] pulse_width;
    logic        touch_db;
    logic        moving;
    logic        is_open;

    int n_cmp = 0;
    int n_bad = 0;

    servo_motion_ctrl #(
        .MIN_PW(32'd100),
        .MAX_PW(32'd200),
        .STEP(32'd30),
        .DEBOUNCE_CYCLES(32'd4)
    ) dut (
        .int_osc(int_osc),
        .reset(reset),
        .touch_in(touch_in),
        .frame_start(frame_start),
        .pulse_width(pulse_width),
        .touch_db(touch_db),
        .moving(moving),
        .is_open(is_open)
    );

    always #5 int_osc = ~int_osc;

    task automatic cyc();
        @(posedge int_osc);
        #1;
    endtask

    // One PWM frame: pulse, check the new width, then hold it for 49 cycles.
    task automatic frame_pulse(input logic [31:0] exp_pw,
                               input logic exp_mov,
                               input logic [1:0] exp_st);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        n_cmp++;
        if (pulse_width !== exp_pw) begin
            n_bad++;
            $display("FAIL frame_pw: got %0d want %0d", pulse_width, exp_pw);
        end
        cyc();
        n_cmp++;
        if (moving !== exp_mov) begin
            n_bad++;
            $display("FAIL frame_moving: got %b want %b (pw %0d)", moving, exp_mov, exp_pw);
        end
        n_cmp++;
        if (2'(dut.state_q) !== exp_st) begin
            n_bad++;
            $display("FAIL frame_state: got %0d want %0d (pw %0d)", dut.state_q, exp_st, exp_pw);
        end
        repeat (48) begin
            cyc();
            n_cmp++;
            if (pulse_width !== exp_pw) begin
                n_bad++;
                $display("FAIL hold_pw: got %0d want %0d", pulse_width, exp_pw);
            end
        end
    endtask

    // Release, let touch_db fall, press again; rise lands 6 edges later.
    task automatic press(input logic exp_open);
        touch_in = 1'b0;
        repeat (8) cyc();
        n_cmp++;
        if (touch_db !== 1'b0) begin
            n_bad++;
            $display("FAIL press_release: got %b want 0", touch_db);
        end
        touch_in = 1'b1;
        repeat (6) cyc();
        n_cmp++;
        if (touch_db !== 1'b1) begin
            n_bad++;
            $display("FAIL press_db: got %b want 1", touch_db);
        end
        cyc();
        n_cmp++;
        if (is_open !== exp_open) begin
            n_bad++;
            $display("FAIL press_open: got %b want %b", is_open, exp_open);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                reset    = 1'b0;
                touch_in = 1'b0;
            end else begin
                touch_in = i[0];
            end
            cyc();
            n_cmp++;
            if (pulse_width !== 32'd100 || touch_db !== 1'b0 ||
                is_open !== 1'b0 || moving !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_outs[%0d]: got pw %0d db %b open %b mov %b want 100 0 0 0",
                         i, pulse_width, touch_db, is_open, moving);
            end
        end
        repeat (3) cyc();
    endtask

    task automatic test_debounce();
        touch_in = 1'b1;
        repeat (3) cyc();
        touch_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            n_cmp++;
            if (touch_db !== 1'b0 || pulse_width !== 32'd100) begin
                n_bad++;
                $display("FAIL glitch_reject[%0d]: got db %b pw %0d want 0 100",
                         i, touch_db, pulse_width);
            end
        end
        touch_in = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            n_cmp++;
            if (touch_db !== (k >= 6)) begin
                n_bad++;
                $display("FAIL db_rise[%0d]: got %b want %b", k, touch_db, k >= 6);
            end
            n_cmp++;
            if (is_open !== (k >= 7)) begin
                n_bad++;
                $display("FAIL open_rise[%0d]: got %b want %b", k, is_open, k >= 7);
            end
            n_cmp++;
            if (moving !== (k >= 8)) begin
                n_bad++;
                $display("FAIL moving_rise[%0d]: got %b want %b", k, moving, k >= 8);
            end
        end
    endtask

    task automatic test_open_ramp();
        frame_pulse(32'd130, 1'b1, 2'd1);
        frame_pulse(32'd160, 1'b1, 2'd1);
        frame_pulse(32'd190, 1'b1, 2'd1);
        frame_pulse(32'd200, 1'b0, 2'd2);
    endtask

    task automatic test_coincident();
        touch_in = 1'b0;
        repeat (8) cyc();
        touch_in = 1'b1;
        repeat (6) cyc();
        n_cmp++;
        if (touch_db !== 1'b1 || pulse_width !== 32'd200) begin
            n_bad++;
            $display("FAIL coin_pre: got db %b pw %0d want 1 200", touch_db, pulse_width);
        end
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        n_cmp++;
        if (pulse_width !== 32'd170) begin
            n_bad++;
            $display("FAIL coin_pw: got %0d want 170", pulse_width);
        end
        n_cmp++;
        if (is_open !== 1'b0) begin
            n_bad++;
            $display("FAIL coin_open: got %b want 0", is_open);
        end
        repeat (49) cyc();
        frame_pulse(32'd140, 1'b1, 2'd3);
        frame_pulse(32'd110, 1'b1, 2'd3);
        frame_pulse(32'd100, 1'b0, 2'd0);
    endtask

    task automatic test_reversal();
        press(1'b1);
        frame_pulse(32'd130, 1'b1, 2'd1);
        frame_pulse(32'd160, 1'b1, 2'd1);
        press(1'b0);
        n_cmp++;
        if (pulse_width !== 32'd160) begin
            n_bad++;
            $display("FAIL rev_hold: got %0d want 160", pulse_width);
        end
        frame_pulse(32'd130, 1'b1, 2'd3);
        frame_pulse(32'd100, 1'b0, 2'd0);
    endtask

    task automatic test_reset_mid();
        press(1'b1);
        frame_pulse(32'd130, 1'b1, 2'd1);
        frame_pulse(32'd160, 1'b1, 2'd1);
        touch_in = 1'b0;
        repeat (4) cyc();
        n_cmp++;
        if (dut.db_cnt_q !== 32'd2) begin
            n_bad++;
            $display("FAIL mid_cnt_pre: got %0d want 2", dut.db_cnt_q);
        end
        reset = 1'b1;
        frame_start = 1'b1;
        cyc();
        reset = 1'b0;
        frame_start = 1'b0;
        n_cmp++;
        if (pulse_width !== 32'd100) begin
            n_bad++;
            $display("FAIL mid_pw: got %0d want 100", pulse_width);
        end
        n_cmp++;
        if (2'(dut.state_q) !== 2'd0) begin
            n_bad++;
            $display("FAIL mid_state: got %0d want 0", dut.state_q);
        end
        n_cmp++;
        if (dut.db_cnt_q !== 32'd0) begin
            n_bad++;
            $display("FAIL mid_cnt: got %0d want 0", dut.db_cnt_q);
        end
        n_cmp++;
        if (touch_db !== 1'b0 || is_open !== 1'b0 || moving !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_outs: got db %b open %b mov %b want 0 0 0",
                     touch_db, is_open, moving);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_open_ramp();
        test_coincident();
        test_reversal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/servo_motion_ctrl.md
# servo_motion_ctrl

Upstream command stage for the servo PWM generator. Synchronizes and debounces the capacitive-touch GPIO line from the MCU. Each debounced touch toggles the servo between a closed and an open position. The commanded pulse width ramps toward the target in fixed steps, updated only at PWM frame boundaries, so the PWM stage never sees a width change mid-frame.

## Interface

Parameters:
- `MIN_PW`, default 24000: closed-position pulse width in `int_osc` cycles (1 ms at 24 MHz).
- `MAX_PW`, default 48000: open-position pulse width in cycles (2 ms). Must satisfy MIN_PW < MAX_PW < 2^32.
- `STEP`, default 1200: maximum pulse-width change per PWM frame, in cycles. Must be ≥ 1.
- `DEBOUNCE_CYCLES`, default 240000: number of consecutive identical synchronized samples needed to accept a new level (10 ms). Must be ≥ 1.

Ports:
- `int_osc`, in, 1: sole clock (24 MHz HSOSC).
- `reset`, in, 1: synchronous, active-high reset.
- `touch_in`, in, 1: raw, asynchronous touch level from the MCU GPIO; 1 = touched.
- `frame_start`, in, 1: one-cycle pulse from the PWM stage when its period counter wraps to 0.
- `pulse_width`, out, 32: commanded high time in cycles; the PWM stage compares its counter against this value.
- `touch_db`, out, 1: debounced touch level.
- `moving`, out, 1: high while `pulse_width` ≠ target.
- `is_open`, out, 1: current target; 1 = MAX_PW, 0 = MIN_PW.

## Operation

Synchronizer:
- `touch_in` passes through two flops (`s1`, `s2`). Only `s2` is used downstream.

Debouncer:
- Counter `db_cnt` (32 bit) and register `touch_db`.
- If `s2 == touch_db`, `db_cnt` clears to 0.
- Otherwise `db_cnt` increments. When it reaches DEBOUNCE_CYCLES−1 while `s2` still differs, `touch_db` takes the value of `s2` and `db_cnt` clears.
- `touch_rise` is a one-cycle internal pulse on the cycle `touch_db` goes 0→1. Falling edges do nothing.

Target FSM has four states: CLOSED, OPENING, OPEN, CLOSING.
- On `touch_rise`:
  - CLOSED → OPENING.
  - OPEN → CLOSING.
  - OPENING → CLOSING (reversal).
  - CLOSING → OPENING (reversal).
- `is_open` = 1 in OPENING and OPEN.
- OPENING → OPEN when `pulse_width` reaches MAX_PW. CLOSING → CLOSED when `pulse_width` reaches MIN_PW.

Ramp:
- `pulse_width` changes only in the cycle after `frame_start` is sampled high.
- Update toward the target: if |target − pulse_width| ≤ STEP, load the target exactly. Otherwise add or subtract STEP.
- Overshoot and underflow are impossible; `pulse_width` always stays within [MIN_PW, MAX_PW].
- Comparisons and subtraction use 32-bit unsigned arithmetic on the ordered difference (larger − smaller).

Simultaneous events:
- If `touch_rise` and `frame_start` occur in the same cycle, the FSM direction update takes effect first. The ramp step in the following cycle uses the new target.

Outputs:
- `moving` = (`pulse_width` ≠ target), registered.

Reset:
- Every register returns to its reset value: `s1` = `s2` = 0, `db_cnt` = 0, `touch_db` = 0, state CLOSED, `pulse_width` = MIN_PW, `moving` = 0, `is_open` = 0.
- Reset asserted in the middle of a ramp or a debounce takes priority over all other events in that cycle.

## Timing

- `touch_in` edge to `touch_db` change: 2 synchronizer cycles + DEBOUNCE_CYCLES cycles, provided the input stays stable.
- Any glitch shorter than DEBOUNCE_CYCLES cycles is rejected.
- `touch_db` rise to state and `is_open` change: 1 cycle.
- `frame_start` to `pulse_width` update: 1 cycle.
- `moving` and the OPEN/CLOSED transition settle in the cycle after `pulse_width` reaches the target.
- Full travel takes ceil((MAX_PW−MIN_PW)/STEP) frames: 20 frames (400 ms) with the defaults.
- `pulse_width` is stable for the whole of every PWM frame.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4, MIN_PW=100, MAX_PW=200, STEP=30, and `frame_start` every 50 cycles.

1. Reset: hold `reset` for 3 cycles with `touch_in` toggling → `pulse_width`=100, `touch_db`=0, `is_open`=0, `moving`=0 throughout reset and in the first cycle after it.
2. Debounce reject: pulse `touch_in` high for 3 cycles → `touch_db` stays 0 and `pulse_width` stays 100. Hold high for 10 cycles → `touch_db` rises exactly 6 cycles after the edge; `is_open`=1 one cycle later.
3. Open ramp: after touch, `pulse_width` over successive frames = 130, 160, 190, 200. `moving` falls and the state becomes OPEN in the cycle after 200 is loaded. No change occurs between `frame_start` pulses.
4. Reversal: touch while `pulse_width`=160 and OPENING → `is_open`=0 and subsequent frames give 130, 100. The state ends in CLOSED and `pulse_width` never exceeds 160.
5. Coincident events: `touch_rise` in the same cycle as `frame_start` while OPEN at 200 → the next cycle gives `pulse_width`=170, not 200.
6. Reset mid-ramp: assert `reset` when `pulse_width`=160 and `db_cnt`=2 → next cycle `pulse_width`=100, state CLOSED, `db_cnt`=0.
